pe_array_seq: RTL and testbench
===============================

Name: pe_array_seq

Overview:
- Top-level sequencer for an N x N systolic PE array.
- Per tile it runs four phases in order:
  - preloads the accumulator regfiles with C (we),
  - streams K operand beats into the corner PE (en seed),
  - drains the skewed wavefront and, for INT4 only, fires the compute-mode (cm) pass,
  - writes results back word by word under a ready handshake (wben/out_ready).
- Sits between the tile-level address generator / operand buffers and the PE array; one instance per array.

Parameters:
- N, 4, array dimension and accumulator words per PE regfile.
- K_W, 8, width of the K-length field.
- FP_LAT, 1, extra pipeline cycles of the FP MAC path relative to INT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  start-tile pulse; sampled only in IDLE.
- datatype  in  2  0=FP32, 1=FP16, 2=INT8, 3=INT4; latched on accepted start.
- mixed  in  1  FP16 mixed-precision flag; latched on start, driven to mixed_o.
- k_len  in  K_W  number of operand beats; latched on start.
- c_valid  in  1  C word available from source.
- c_ready  out  1  sequencer accepts C word.
- we  out  1  regfile write strobe to PEs; equals c_valid & c_ready.
- ab_valid  in  1  operand beat (a row and b column) present at array edge.
- ab_ready  out  1  beat consumed this cycle.
- en_seed  out  1  data enable into PE(0,0) (enleft/enup of corner).
- cm_seed  out  1  compute-mode enable into PE(0,0).
- wben  out  1  writeback enable to PEs.
- out_ready  in  1  result sink ready; forwarded to PEs.
- out_valid  out  1  wben & out_ready; the PE out_sum word is valid the next cycle.
- mixed_o  out  1  latched mixed flag.
- datatype_o  out  2  latched datatype.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on exit of WB.
- err  out  1  sticky: cm phase requested for non-INT4; cleared on start.

Behaviour:
- Reset (async): state=IDLE, all counters 0, all outputs 0, latched fields 0.
- State IDLE:
  - start=1 latches datatype, mixed and k_len, clears err, and moves to LOAD next cycle.
  - start while busy is ignored.
- State LOAD:
  - c_ready=1. Each c_valid&c_ready handshake is one we and increments ld_cnt.
  - After N handshakes the next state is COMPUTE, or WB if k_len==0 (result = C).
  - c_valid low stalls with no timeout.
- State COMPUTE:
  - ab_ready=1 and en_seed=ab_valid; beat counter increments on ab_valid.
  - A stall (ab_valid=0) drops en_seed for that cycle only; PE skew propagates the bubble.
  - After k_len beats the next state is DRAIN.
- State DRAIN:
  - Counts D = 2*(N-1) + 1 + (FP ? FP_LAT : 0) cycles with en_seed=0. For N=4: INT=7, FP=8.
  - On expiry: INT4 goes to CM; all other types go to WB.
- State CM (INT4 only):
  - cm_seed=1 for 1 cycle, then waits 2*(N-1)+1 cycles for cm to reach PE(N-1,N-1), then goes to WB.
  - Reaching CM with datatype!=3 is impossible by construction. A defensive check sets err and skips to WB.
- State WB:
  - wben=1; wb_cnt increments on out_ready.
  - After N accepted words, deassert wben, pulse done, return to IDLE.
  - out_ready low holds wben with no progress.
- Counters:
  - ld_cnt and wb_cnt are log2(N)+1 bits; the beat counter is K_W bits.
  - Terminal compare is on count == limit-1 with handshake, so the counters never wrap.
- Only one of we / en_seed / cm_seed / wben is high in any cycle.
- Reset mid-operation aborts to IDLE immediately. No done pulse; PE state is the datapath's concern.
- datatype_o and mixed_o hold their latched values until the next start.

Optional Feature:
- SEQ_PERF_CNT_EN defined: adds output perf_cycles (32b) and output perf_stalls (32b).
  - perf_cycles counts busy cycles of the current tile.
  - perf_stalls counts COMPUTE cycles with ab_valid=0 plus WB cycles with out_ready=0.
  - Both clear on accepted start and saturate at all-ones.
- Not defined: the ports do not exist and there is no counter logic.

Test Plan:
- INT8, k_len=3, c_valid and ab_valid and out_ready tied 1, N=4:
  - LOAD we high cycles 1-4, COMPUTE en_seed cycles 5-7, DRAIN 7 cycles, WB 4 cycles.
  - done at cycle 18, busy low after.
- FP16 with mixed=1, k_len=2:
  - DRAIN lasts 8 cycles; mixed_o=1 and datatype_o=1 throughout.
  - No cm_seed ever; done follows 4 WB handshakes.
- INT4, k_len=1:
  - After a 7-cycle DRAIN, cm_seed pulses exactly 1 cycle, then 7 wait cycles, then WB.
  - err stays 0.
- Backpressure, INT8 with k_len=4:
  - Stimulus: ab_valid pattern 1,0,1,1,0,1; out_ready pattern 1,0,0,1,1,1.
  - Expected: en_seed mirrors the ab_valid pattern; wben stays high for 6 cycles; exactly 4 out_valid pulses.
- k_len=0: LOAD (4 we) goes directly to WB; no en_seed or cm_seed pulses.
- Reset and start edge cases:
  - Assert rst for 1 cycle mid-COMPUTE: all outputs 0 that cycle, state IDLE, no done.
  - A start during busy is ignored.
  - With SEQ_PERF_CNT_EN, perf_stalls equals the number of injected stall cycles.

Source files
------------

// File: rtl/pe_array_seq.sv
// pe_array_seq: per-tile sequencer for an N x N systolic PE array.
// Phases: LOAD (C preload) -> COMPUTE (K beats into corner PE) -> DRAIN
// (wavefront flush) -> CM (INT4 compute-mode pass) -> WB (handshaked writeback).
// Optional build macro SEQ_PERF_CNT_EN adds saturating perf_cycles/perf_stalls.
module pe_array_seq #(
   parameter int N      = 4,
   parameter int K_W    = 8,
   parameter int FP_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:0]     datatype,
   input  logic           mixed,
   input  logic [K_W-1:0] k_len,
   input  logic           c_valid,
   output logic           c_ready,
   output logic           we,
   input  logic           ab_valid,
   output logic           ab_ready,
   output logic           en_seed,
   output logic           cm_seed,
   output logic           wben,
   input  logic           out_ready,
   output logic           out_valid,
   output logic           mixed_o,
   output logic [1:0]     datatype_o,
   output logic           busy,
   output logic           done,
   output logic           err
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]    perf_cycles,
   output logic [31:0]    perf_stalls
`endif
);

   localparam int CNT_W = $clog2(N) + 1;
   // cycles for an edge event to cross the skewed array to PE(N-1,N-1)
   localparam int SKEW  = 2 * (N - 1) + 1;
   localparam int TMR_W = $clog2(SKEW + FP_LAT + 1);
   localparam logic [1:0] DT_INT4 = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_CM, S_WB
   } state_t;

   state_t           state;
   logic [1:0]       dt_q;
   logic             mixed_q;
   logic [K_W-1:0]   k_q;
   logic [K_W-1:0]   beat_cnt;
   logic [CNT_W-1:0] ld_cnt;
   logic [CNT_W-1:0] wb_cnt;
   logic [TMR_W-1:0] tmr;
   logic [TMR_W-1:0] drain_last;
   logic             ld_last;
   logic             wb_last;

   // FP types (FP32/FP16) carry the longer MAC pipeline, so drain waits longer
   assign drain_last = dt_q[1] ? TMR_W'(SKEW - 1) : TMR_W'(SKEW + FP_LAT - 1);
   assign ld_last    = (ld_cnt == CNT_W'(N - 1));
   assign wb_last    = (wb_cnt == CNT_W'(N - 1));

   // Strobes are decoded from state; handshake strobes qualify with inputs
   assign c_ready    = (state == S_LOAD);
   assign we         = c_ready & c_valid;
   assign ab_ready   = (state == S_COMPUTE);
   assign en_seed    = ab_ready & ab_valid;
   assign cm_seed    = (state == S_CM) && (tmr == '0) && (dt_q == DT_INT4);
   assign wben       = (state == S_WB);
   assign out_valid  = wben & out_ready;
   assign done       = out_valid & wb_last;
   assign busy       = (state != S_IDLE);
   assign datatype_o = dt_q;
   assign mixed_o    = mixed_q;

   // Tile FSM: phase transitions, counters and latched tile fields
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         dt_q     <= '0;
         mixed_q  <= 1'b0;
         k_q      <= '0;
         beat_cnt <= '0;
         ld_cnt   <= '0;
         wb_cnt   <= '0;
         tmr      <= '0;
         err      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  dt_q     <= datatype;
                  mixed_q  <= mixed;
                  k_q      <= k_len;
                  err      <= 1'b0;
                  beat_cnt <= '0;
                  ld_cnt   <= '0;
                  wb_cnt   <= '0;
                  tmr      <= '0;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (c_valid) begin
                  if (ld_last) begin
                     ld_cnt <= '0;
                     // k_len==0: the result is simply the preloaded C
                     state  <= (k_q == '0) ? S_WB : S_COMPUTE;
                  end else begin
                     ld_cnt <= ld_cnt + 1'b1;
                  end
               end
            end
            S_COMPUTE: begin
               if (ab_valid) begin
                  if (beat_cnt == k_q - K_W'(1)) begin
                     beat_cnt <= '0;
                     tmr      <= '0;
                     state    <= S_DRAIN;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (tmr == drain_last) begin
                  tmr   <= '0;
                  state <= (dt_q == DT_INT4) ? S_CM : S_WB;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            S_CM: begin
               if (dt_q != DT_INT4) begin
                  // unreachable by construction; flag and fall through
                  err   <= 1'b1;
                  tmr   <= '0;
                  state <= S_WB;
               end else if (tmr == TMR_W'(SKEW)) begin
                  // cycle 0 fired cm_seed, SKEW more let it reach the far corner
                  tmr   <= '0;
                  state <= S_WB;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            S_WB: begin
               if (out_ready) begin
                  if (wb_last) begin
                     wb_cnt <= '0;
                     state  <= S_IDLE;
                  end else begin
                     wb_cnt <= wb_cnt + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic stall_cyc;
   assign stall_cyc = (ab_ready & ~ab_valid) | (wben & ~out_ready);

   // Saturating per-tile busy/stall counters, cleared on accepted start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cycles <= '0;
         perf_stalls <= '0;
      end else if (state == S_IDLE && start) begin
         perf_cycles <= '0;
         perf_stalls <= '0;
      end else begin
         if (busy && perf_cycles != '1)      perf_cycles <= perf_cycles + 1'b1;
         if (stall_cyc && perf_stalls != '1) perf_stalls <= perf_stalls + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pe_array_seq.sv
// tb_pe_array_seq: scoreboard bench for pe_array_seq. Tiles are issued with
// random or patterned handshake inputs; a per-tile expectation (phase lengths
// derived from tile parameters) is queued at start and checked by a monitor
// when done fires. Per-cycle protocol rules are checked continuously.
module tb_pe_array_seq;
   localparam int N      = 4;
   localparam int K_W    = 8;
   localparam int FP_LAT = 1;
   localparam int SKEW   = 2 * (N - 1) + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [1:0]     datatype = '0;
   logic           mixed = 1'b0;
   logic [K_W-1:0] k_len = '0;
   logic           c_valid = 1'b0, ab_valid = 1'b0, out_ready = 1'b0;
   logic           c_ready, we, ab_ready, en_seed, cm_seed, wben, out_valid;
   logic           mixed_o, busy, done, err;
   logic [1:0]     datatype_o;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0]    perf_cycles, perf_stalls;
`endif

   pe_array_seq #(.N(N), .K_W(K_W), .FP_LAT(FP_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .datatype(datatype), .mixed(mixed),
      .k_len(k_len), .c_valid(c_valid), .c_ready(c_ready), .we(we),
      .ab_valid(ab_valid), .ab_ready(ab_ready), .en_seed(en_seed),
      .cm_seed(cm_seed), .wben(wben), .out_ready(out_ready),
      .out_valid(out_valid), .mixed_o(mixed_o), .datatype_o(datatype_o),
      .busy(busy), .done(done), .err(err)
`ifdef SEQ_PERF_CNT_EN
      , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int dt; int mx; int k; int ab_st; int wb_st;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
      end
   endtask

   // ---------------- driver: per-cycle handshake inputs ----------------
   int p_c = 100, p_ab = 100, p_or = 100;
   int ab_pat[$];
   int or_pat[$];

   initial forever begin
      @(posedge clk); #1;
      c_valid = ($urandom_range(99) < p_c);
      if (ab_ready && ab_pat.size() > 0) ab_valid = (ab_pat.pop_front() != 0);
      else                               ab_valid = ($urandom_range(99) < p_ab);
      if (wben && or_pat.size() > 0)     out_ready = (or_pat.pop_front() != 0);
      else                               out_ready = ($urandom_range(99) < p_or);
   end

   // ---------------- monitor / scoreboard ----------------
   int cyc, n_we, n_en, n_cm, n_ov, n_wben, st_c, st_ab, st_wb;
   int last_en, first_post, cm_at, first_wb, done_cnt = 0;
   int perf_pending = 0, perf_cyc_exp, perf_st_exp;
   int m_d, m_base;
   bit m_cmw;
   exp_t me;

   function automatic void clr_acc();
      cyc = 0; n_we = 0; n_en = 0; n_cm = 0; n_ov = 0; n_wben = 0;
      st_c = 0; st_ab = 0; st_wb = 0;
      last_en = -1; first_post = -1; cm_at = -1; first_wb = -1;
   endfunction

   initial begin
      clr_acc();
      forever begin
         @(negedge clk);
         if (rst) begin
            clr_acc();
            perf_pending = 0;
            continue;
         end
         if (perf_pending != 0) begin
            chk("busy_after_done", busy, 0);
`ifdef SEQ_PERF_CNT_EN
            chk("perf_cycles", perf_cycles, perf_cyc_exp);
            chk("perf_stalls", perf_stalls, perf_st_exp);
`endif
            perf_pending = 0;
         end
         if (busy) begin
            cyc++;
            chk("onehot", ((int'(we) + int'(en_seed) + int'(cm_seed) + int'(wben)) <= 1), 1);
            chk("we_rule", we, c_valid & c_ready);
            chk("en_rule", en_seed, ab_ready & ab_valid);
            chk("ov_rule", out_valid, wben & out_ready);
            if (we) n_we++;
            if (en_seed) begin n_en++; last_en = cyc; end
            if (cm_seed) begin n_cm++; cm_at = cyc; end
            if (out_valid) n_ov++;
            if (wben) begin n_wben++; if (first_wb < 0) first_wb = cyc; end
            if ((cm_seed || wben) && first_post < 0) first_post = cyc;
            if (c_ready && !c_valid) st_c++;
            if (ab_ready && !ab_valid) st_ab++;
            if (wben && !out_ready) st_wb++;
         end else begin
            chk("idle_quiet", {we, en_seed, cm_seed, wben, out_valid, c_ready, ab_ready, done}, 0);
         end
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               me    = exp_q.pop_front();
               m_d   = SKEW + ((me.dt < 2) ? FP_LAT : 0);
               m_cmw = (me.dt == 3) && (me.k > 0);
               m_base = N + me.k + ((me.k > 0) ? m_d : 0) + (m_cmw ? 1 + SKEW : 0) + N;
               chk("busy_len", cyc, m_base + st_c + st_ab + st_wb);
               chk("we_count", n_we, N);
               chk("en_count", n_en, me.k);
               chk("cm_count", n_cm, int'(m_cmw));
               chk("ov_count", n_ov, N);
               chk("wben_cycles", n_wben, N + st_wb);
               if (me.k > 0) chk("drain_len", first_post - last_en - 1, m_d);
               if (m_cmw)    chk("cm_wait", first_wb - cm_at - 1, SKEW);
               chk("datatype_o", datatype_o, me.dt);
               chk("mixed_o", mixed_o, me.mx);
               chk("err", err, 0);
               if (me.ab_st >= 0) chk("ab_stalls", st_ab, me.ab_st);
               if (me.wb_st >= 0) chk("wb_stalls", st_wb, me.wb_st);
            end
            perf_pending = 1;
            perf_cyc_exp = cyc;
            perf_st_exp  = st_ab + st_wb;
            clr_acc();
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue_start(input int dt, input int mx, input int k);
      exp_t e;
      int n = 0;
      while (busy && n < 3000) begin @(posedge clk); #2; n++; end
      if (busy) chk("idle_timeout", 1, 0);
      e.dt = dt; e.mx = mx; e.k = k; e.ab_st = -1; e.wb_st = -1;
      datatype = 2'(dt); mixed = mx[0]; k_len = K_W'(k); start = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #2;
      start = 1'b0;
      // scramble inputs to prove the fields were latched
      datatype = 2'($urandom); mixed = 1'($urandom); k_len = K_W'($urandom);
   endtask

   task automatic run_tile(input int dt, input int mx, input int k,
                           input int ab_st, input int wb_st, input bit inj);
      int d0, n;
      d0 = done_cnt;
      issue_start(dt, mx, k);
      exp_q[exp_q.size()-1].ab_st = ab_st;
      exp_q[exp_q.size()-1].wb_st = wb_st;
      if (inj) begin
         repeat (3) @(posedge clk);
         #2;
         chk("inj_busy", busy, 1);
         start = 1'b1; datatype = 2'(dt ^ 3); mixed = ~mx[0]; k_len = 1;
         @(posedge clk); #2;
         start = 1'b0;
      end
      n = 0;
      while (done_cnt == d0 && n < 3000) begin @(posedge clk); n++; end
      chk("tile_done", (done_cnt != d0), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {c_ready, we, ab_ready, en_seed, cm_seed, wben, out_valid, done}, 0);
      chk("rst_latched", {datatype_o, mixed_o, err}, 0);
      @(posedge clk); #2;
      rst = 1'b0;

      // all handshakes always ready
      run_tile(2, 0, 3, 0, 0, 0);   // INT8, 18-cycle tile
      run_tile(1, 1, 2, 0, 0, 0);   // FP16 mixed
      run_tile(3, 0, 1, 0, 0, 0);   // INT4 with cm pass
      run_tile(0, 0, 2, 0, 0, 0);   // FP32
      run_tile(2, 0, 0, 0, 0, 0);   // k_len=0 straight to WB

      // patterned backpressure
      ab_pat = '{1, 0, 1, 1, 0, 1};
      or_pat = '{1, 0, 0, 1, 1, 1};
      run_tile(2, 0, 4, 2, 2, 0);

      // start while busy is ignored
      run_tile(2, 0, 5, 0, 0, 1);

      // reset mid-COMPUTE
      issue_start(2, 1, 6);
      n = 0;
      while (!ab_ready && n < 100) begin @(posedge clk); #2; n++; end
      chk("reach_compute", ab_ready, 1);
      @(posedge clk); #2;
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_strobes", {c_ready, we, ab_ready, en_seed, cm_seed, wben, out_valid, done}, 0);
      chk("midrst_latched", {datatype_o, mixed_o, err}, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      exp_q.delete();
      repeat (30) @(posedge clk);
      #2;
      chk("midrst_no_done", done_cnt, d0);
      chk("midrst_idle", busy, 0);

      // randomized tiles with random stalls
      p_c = 70; p_ab = 65; p_or = 60;
      for (int t = 0; t < 24; t++)
         run_tile($urandom_range(3), $urandom_range(1), $urandom_range(7), -1, -1, 0);
      run_tile(3, 1, 20, -1, -1, 0);

      repeat (3) @(posedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
